// File: rtl/bus_protocol_pkg.sv
// Shared FSM state and burst-type encodings for the bus protocol master.
package bus_protocol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BURST_SINGLE = 2'b00,
    BURST_INCR   = 2'b01,
    BURST_WRAP   = 2'b10,
    BURST_FIXED  = 2'b11
  } burst_type_t;

  localparam logic [7:0] BURST_LEN_SINGLE = 8'd0;

endpackage

// File: rtl/bus_protocol_master.sv
// Single-outstanding bus master IDLE->REQ->RESP (>=3 cycles/txn); request_stall holds REQ, cmd_ready low until rsp consumed.
// Optional stall watchdog enabled by BUS_MASTER_TIMEOUT_EN; aborts to an error/timeout response after TIMEOUT_CYCLES stalls.
module bus_protocol_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wen,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strobe,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    rsp_is_write,
  output logic                    wen,
  output logic                    ren,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] strobe,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    error,
  input  logic                    request_stall,
  output logic                    is_burst,
  output logic [1:0]              burst_type,
  output logic [7:0]              burst_length,
  output logic                    secure_transfer
);
  import bus_protocol_pkg::*;

  localparam int SW = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("bus_protocol_master: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 2");
  end

  state_t                state, state_next;
  logic                  lat_wen;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [SW-1:0]         lat_strobe;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_error_q, rsp_timeout_q, rsp_is_write_q;
  logic                  accept, complete, abort;

  assign accept   = (state == IDLE) && cmd_valid && !reset;
  assign complete = (state == REQ) && !request_stall;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt;

  // Counter sits at zero outside REQ, so it is clear on every REQ entry.
  assign abort = (state == REQ) && request_stall && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state != REQ || !request_stall) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    rsp_error    = 1'b0;
    rsp_timeout  = 1'b0;
    rsp_is_write = 1'b0;
    wen          = 1'b0;
    ren          = 1'b0;
    addr         = '0;
    wdata        = '0;
    strobe       = '0;
    unique case (state)
      IDLE: begin
        cmd_ready = !reset;
        if (accept) state_next = REQ;
      end
      REQ: begin
        wen    = lat_wen;
        ren    = !lat_wen;
        addr   = lat_addr;
        wdata  = lat_wen ? lat_wdata : '0;
        strobe = lat_wen ? lat_strobe : '0;
        if (complete || abort) state_next = RESP;
      end
      RESP: begin
        rsp_valid    = 1'b1;
        rsp_rdata    = rsp_rdata_q;
        rsp_error    = rsp_error_q;
        rsp_timeout  = rsp_timeout_q;
        rsp_is_write = rsp_is_write_q;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_wen        <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_strobe     <= '0;
      rsp_rdata_q    <= '0;
      rsp_error_q    <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      rsp_is_write_q <= 1'b0;
    end else begin
      if (accept) begin
        lat_wen    <= cmd_wen;
        lat_addr   <= cmd_addr;
        lat_wdata  <= cmd_wdata;
        lat_strobe <= cmd_strobe;
      end
      // abort needs request_stall high, so it never coincides with a completion.
      if (complete || abort) begin
        rsp_is_write_q <= lat_wen;
        rsp_timeout_q  <= abort;
        rsp_error_q    <= abort | error;
        rsp_rdata_q    <= (abort || lat_wen) ? '0 : rdata;
      end
    end
  end

  assign is_burst        = 1'b0;
  assign burst_type      = BURST_SINGLE;
  assign burst_length    = BURST_LEN_SINGLE;
  assign secure_transfer = 1'b0;

endmodule

// File: tb/tb_bus_protocol_master.sv
// Scoreboard bench for bus_protocol_master: expected responses queued at command time, compared on response.
module tb_bus_protocol_master;

  localparam int TO = 4;
`ifdef BUS_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wen = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_strobe = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error, rsp_timeout, rsp_is_write;
  logic        wen, ren;
  logic [31:0] addr, wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata = '0;
  logic        error = 1'b0, request_stall = 1'b0;
  logic        is_burst, secure_transfer;
  logic [1:0]  burst_type;
  logic [7:0]  burst_length;

  int tests_run = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic        isw;
    int          cycles;
  } exp_t;

  typedef struct {
    int          req_cycles;
    bit          stable;
    bit          bus_ok;
    bit          rsp_seen;
    bit          wait_ok;
    bit          idle_after;
    bit          hung;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic        isw;
  } obs_t;

  exp_t sb[$];

  bus_protocol_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wen(cmd_wen),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .rsp_is_write(rsp_is_write),
    .wen(wen), .ren(ren), .addr(addr), .wdata(wdata), .strobe(strobe),
    .rdata(rdata), .error(error), .request_stall(request_stall),
    .is_burst(is_burst), .burst_type(burst_type), .burst_length(burst_length),
    .secure_transfer(secure_transfer)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(logic w, int stalls, logic [31:0] rd, logic er);
    exp_t e;
    if (TO_EN && stalls >= TO) begin
      e.rdata = '0; e.err = 1'b1; e.to = 1'b1; e.isw = w; e.cycles = TO;
    end else begin
      e.rdata = w ? 32'h0 : rd; e.err = er; e.to = 1'b0; e.isw = w; e.cycles = stalls + 1;
    end
    return e;
  endfunction

  // Drives one command, plays the bus slave and response consumer, and reports what it saw.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int stalls, input logic [31:0] rd,
                         input logic er, input int rsp_wait, output obs_t o);
    logic [31:0] a0, d0, rd0;
    logic [3:0]  s0;
    logic        w0, r0, er0, to0, isw0;
    int          k, guard;
    o.req_cycles = 0; o.stable = 1; o.bus_ok = 1; o.rsp_seen = 0; o.wait_ok = 1;
    o.idle_after = 0; o.hung = 0; o.rdata = '0; o.err = 0; o.to = 0; o.isw = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wen = w; cmd_addr = a; cmd_wdata = d; cmd_strobe = s;
    rdata = rd; error = er; request_stall = 1'b0;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) o.hung = 1;
    sb.push_back(model(w, stalls, rd, er));
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wen = ~w; cmd_addr = ~a; cmd_wdata = ~d; cmd_strobe = ~s;
    k = 0;
    while ((wen === 1'b1 || ren === 1'b1) && k < 300) begin
      if (k == 0) begin
        a0 = addr; d0 = wdata; s0 = strobe; w0 = wen; r0 = ren;
      end else if (addr !== a0 || wdata !== d0 || strobe !== s0 || wen !== w0 || ren !== r0) begin
        o.stable = 0;
      end
      if (wen === ren || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 ||
          addr !== a || wen !== w || ren !== !w ||
          wdata !== (w ? d : 32'h0) || strobe !== (w ? s : 4'h0) ||
          is_burst !== 1'b0 || burst_type !== 2'b00 || burst_length !== 8'h00 ||
          secure_transfer !== 1'b0)
        o.bus_ok = 0;
      request_stall = (k < stalls);
      k++;
      @(negedge clk);
    end
    request_stall = 1'b0;
    o.req_cycles = k;
    if (k >= 300) o.hung = 1;
    o.rsp_seen = (rsp_valid === 1'b1);
    if (wen !== 1'b0 || ren !== 1'b0 || cmd_ready !== 1'b0) o.wait_ok = 0;
    rd0 = rsp_rdata; er0 = rsp_error; to0 = rsp_timeout; isw0 = rsp_is_write;
    for (int i = 0; i < rsp_wait; i++) begin
      cmd_valid = 1'b1; cmd_wen = ~w; cmd_addr = 32'h5555_0000 + i;
      @(negedge clk);
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || wen !== 1'b0 || ren !== 1'b0 ||
          rsp_rdata !== rd0 || rsp_error !== er0 || rsp_timeout !== to0 || rsp_is_write !== isw0)
        o.wait_ok = 0;
    end
    o.rdata = rsp_rdata; o.err = rsp_error; o.to = rsp_timeout; o.isw = rsp_is_write;
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    o.idle_after = (cmd_ready === 1'b1 && rsp_valid === 1'b0 && rsp_rdata === 32'h0 &&
                    rsp_error === 1'b0 && rsp_timeout === 1'b0 && rsp_is_write === 1'b0 &&
                    wen === 1'b0 && ren === 1'b0);
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else begin
      e.rdata = 'x; e.err = 'x; e.to = 'x; e.isw = 'x; e.cycles = -1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    tests_run++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || wen !== 1'b0 || ren !== 1'b0 || addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b wen=%b ren=%b addr=%h, want all 0",
               cmd_ready, rsp_valid, wen, ren, addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b rsp_rdata=%h, want 1 0 0",
               cmd_ready, rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_read();
    obs_t o; exp_t e; bit ok;
    run_txn(1'b0, 32'h10, 32'h1234_5678, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0, o);
    pop_exp(e, ok);
    tests_run++;
    if (!ok || o.rdata !== e.rdata || o.err !== e.err || o.isw !== e.isw) begin
      fails++;
      $display("FAIL read_rsp: got rdata=%h err=%b isw=%b, want %h %b %b", o.rdata, o.err, o.isw, e.rdata, e.err, e.isw);
    end
    tests_run++;
    if (o.req_cycles != e.cycles || !o.bus_ok || !o.rsp_seen) begin
      fails++;
      $display("FAIL read_bus: req_cycles=%0d bus_ok=%0d rsp_seen=%0d, want %0d 1 1", o.req_cycles, o.bus_ok, o.rsp_seen, e.cycles);
    end
    tests_run++;
    if (!o.idle_after || o.hung) begin
      fails++;
      $display("FAIL read_idle: idle_after=%0d hung=%0d, want 1 0", o.idle_after, o.hung);
    end
  endtask

  task automatic test_write_stall();
    obs_t o; exp_t e; bit ok;
    run_txn(1'b1, 32'h20, 32'hA5A5_A5A5, 4'hF, 3, 32'h1111_1111, 1'b0, 0, o);
    pop_exp(e, ok);
    tests_run++;
    if (!ok || o.rdata !== e.rdata || o.isw !== e.isw || o.err !== e.err || o.to !== e.to) begin
      fails++;
      $display("FAIL write_rsp: got rdata=%h isw=%b err=%b to=%b, want %h %b %b %b",
               o.rdata, o.isw, o.err, o.to, e.rdata, e.isw, e.err, e.to);
    end
    tests_run++;
    if (o.req_cycles != e.cycles || !o.stable || !o.bus_ok) begin
      fails++;
      $display("FAIL write_stall_bus: wen_cycles=%0d stable=%0d bus_ok=%0d, want %0d 1 1", o.req_cycles, o.stable, o.bus_ok, e.cycles);
    end
  endtask

  task automatic test_read_error();
    obs_t o; exp_t e; bit ok;
    run_txn(1'b0, 32'h30, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b1, 0, o);
    pop_exp(e, ok);
    tests_run++;
    if (!ok || o.err !== e.err || o.to !== e.to || o.rdata !== e.rdata) begin
      fails++;
      $display("FAIL read_error: got err=%b to=%b rdata=%h, want %b %b %h", o.err, o.to, o.rdata, e.err, e.to, e.rdata);
    end
    run_txn(1'b1, 32'h34, 32'h0000_00FF, 4'h1, 0, 32'h0, 1'b1, 0, o);
    pop_exp(e, ok);
    tests_run++;
    if (!ok || o.err !== e.err || o.isw !== e.isw || o.rdata !== e.rdata) begin
      fails++;
      $display("FAIL write_error: got err=%b isw=%b rdata=%h, want %b %b %h", o.err, o.isw, o.rdata, e.err, e.isw, e.rdata);
    end
    error = 1'b0;
  endtask

  task automatic test_rsp_backpressure();
    obs_t o; exp_t e; bit ok;
    run_txn(1'b1, 32'h40, 32'h0F0F_0F0F, 4'b0101, 0, 32'h0, 1'b0, 5, o);
    pop_exp(e, ok);
    tests_run++;
    if (!o.wait_ok || !o.rsp_seen) begin
      fails++;
      $display("FAIL rsp_backpressure: wait_ok=%0d rsp_seen=%0d, want 1 1", o.wait_ok, o.rsp_seen);
    end
    tests_run++;
    if (!ok || o.isw !== e.isw || o.rdata !== e.rdata || !o.bus_ok || !o.idle_after) begin
      fails++;
      $display("FAIL backpressure_rsp: isw=%b rdata=%h bus_ok=%0d idle_after=%0d, want %b %h 1 1",
               o.isw, o.rdata, o.bus_ok, o.idle_after, e.isw, e.rdata);
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e; bit ok;
    run_txn(1'b0, 32'h50, 32'h0, 4'h0, TO - 1, 32'h7777_0001, 1'b0, 0, o);
    pop_exp(e, ok);
    tests_run++;
    if (!ok || o.req_cycles != e.cycles || o.to !== e.to || o.err !== e.err || o.rdata !== e.rdata) begin
      fails++;
      $display("FAIL stall_below_limit: cycles=%0d to=%b err=%b rdata=%h, want %0d %b %b %h",
               o.req_cycles, o.to, o.err, o.rdata, e.cycles, e.to, e.err, e.rdata);
    end
    run_txn(1'b0, 32'h54, 32'h0, 4'h0, 100, 32'h7777_0002, 1'b0, 0, o);
    pop_exp(e, ok);
    tests_run++;
    if (!ok || o.req_cycles != e.cycles || o.hung) begin
      fails++;
      $display("FAIL long_stall_cycles: req_cycles=%0d hung=%0d, want %0d 0", o.req_cycles, o.hung, e.cycles);
    end
    tests_run++;
    if (o.to !== e.to || o.err !== e.err || o.rdata !== e.rdata || !o.stable || !o.bus_ok) begin
      fails++;
      $display("FAIL long_stall_rsp: to=%b err=%b rdata=%h stable=%0d bus_ok=%0d, want %b %b %h 1 1",
               o.to, o.err, o.rdata, o.stable, o.bus_ok, e.to, e.err, e.rdata);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wen = 1'b0; cmd_addr = 32'h60; request_stall = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    tests_run++;
    if (ren !== 1'b1 || addr !== 32'h60) begin
      fails++;
      $display("FAIL mid_req_entry: ren=%b addr=%h, want 1 00000060", ren, addr);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (wen !== 1'b0 || ren !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_req_async_reset: wen=%b ren=%b rsp_valid=%b cmd_ready=%b, want 0 0 0 0",
               wen, ren, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0; request_stall = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wen !== 1'b0 || ren !== 1'b0) begin
        fails++;
        $display("FAIL mid_req_after_reset: cmd_ready=%b rsp_valid=%b wen=%b ren=%b, want 1 0 0 0",
                 cmd_ready, rsp_valid, wen, ren);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e; bit ok;
    logic w, er;
    logic [31:0] a, d, rd;
    logic [3:0] s;
    int st, rw;
    for (int n = 0; n < 10; n++) begin
      w = 1'($urandom_range(0, 1)); er = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom; rd = $urandom; s = 4'($urandom_range(0, 15));
      st = $urandom_range(0, 2); rw = $urandom_range(0, 1);
      run_txn(w, a, d, s, st, rd, er, rw, o);
      pop_exp(e, ok);
      tests_run++;
      if (!ok || o.rdata !== e.rdata || o.err !== e.err || o.to !== e.to || o.isw !== e.isw ||
          o.req_cycles != e.cycles || !o.bus_ok || !o.stable || !o.wait_ok || !o.idle_after) begin
        fails++;
        $display("FAIL b2b_%0d: rdata=%h err=%b to=%b isw=%b cyc=%0d ok=%0d%0d%0d%0d, want %h %b %b %b %0d 1111",
                 n, o.rdata, o.err, o.to, o.isw, o.req_cycles, o.bus_ok, o.stable, o.wait_ok, o.idle_after,
                 e.rdata, e.err, e.to, e.isw, e.cycles);
      end
    end
    error = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_read_error();
    test_rsp_backpressure();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
